ram_to_stream: RTL

RAM_TO_STREAM -- requirements
Module: ram_to_stream

---
 rtl/ram_to_stream.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ram_to_stream.sv
// Reads a run of fixed-size blocks from an AXI4 memory and replays the returned
// beats on an AXI-Stream output, throttling read requests so the FIFO never overflows.
module ram_to_stream #(
  parameter int          DW           = 512,
  parameter int          BLOCK_CYCLES = 64,
  parameter int          BANK_BLOCKS  = 8192,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter int          FIFO_DEPTH   = 256
) (
  input  logic          clk,
  input  logic          sys_reset,
  input  logic          start,
  input  logic [31:0]   blocks_to_read,
  output logic          busy,
  output logic [31:0]   ram_blocks_read,
  output logic          read_error,
  output logic [DW-1:0] AXIS_OUT_TDATA,
  output logic          AXIS_OUT_TVALID,
  output logic          AXIS_OUT_TLAST,
  input  logic          AXIS_OUT_TREADY,
  output logic [63:0]   M_AXI_ARADDR,
  output logic [7:0]    M_AXI_ARLEN,
  output logic [2:0]    M_AXI_ARSIZE,
  output logic [1:0]    M_AXI_ARBURST,
  output logic [3:0]    M_AXI_ARID,
  output logic          M_AXI_ARLOCK,
  output logic [3:0]    M_AXI_ARCACHE,
  output logic [3:0]    M_AXI_ARQOS,
  output logic [2:0]    M_AXI_ARPROT,
  output logic          M_AXI_ARVALID,
  input  logic          M_AXI_ARREADY,
  input  logic [DW-1:0] M_AXI_RDATA,
  input  logic          M_AXI_RVALID,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RLAST,
  output logic          M_AXI_RREADY
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam int          PW          = AW + 1;
  localparam logic [63:0] BLOCK_BYTES = 64'(BLOCK_CYCLES) * 64'(DW / 8);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ADDR = 1'b1;

  // Reset asserts immediately but releases only on a clock edge, two flops later.
  logic [1:0] rstSync_q;
  logic       rst;

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      rstSync_q <= 2'b11;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b0};
    end
  end

  assign rst = rstSync_q[1];

  logic          busy_q, busy_d;
  logic [31:0]   nBlocks_q, nBlocks_d;
  logic [39:0]   totalBeats_q, totalBeats_d;
  logic [39:0]   outCount_q, outCount_d;
  logic [31:0]   reqCount_q, reqCount_d;
  logic [63:0]   arAddr_q, arAddr_d;
  logic [0:0]    arState_q, arState_d;
  logic [PW-1:0] credit_q, credit_d;
  logic [31:0]   blocksRead_q, blocksRead_d;
  logic          readErr_q, readErr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [DW-1:0] fifoMem_q [FIFO_DEPTH];

  logic        startAcc;
  logic [31:0] nClamp;
  logic        arFire;
  logic        rPush;
  logic        axisFire;
  logic        fifoEmpty;
  logic        creditOk;
  logic        lastBeat;

  assign nClamp    = (blocks_to_read > 32'(BANK_BLOCKS)) ? 32'(BANK_BLOCKS) : blocks_to_read;
  assign startAcc  = start && !busy_q;
  assign arFire    = (arState_q == ST_ADDR) && M_AXI_ARREADY;
  // Beats arriving outside a run belong to an abandoned run and are dropped.
  assign rPush     = M_AXI_RVALID && M_AXI_RREADY && busy_q;
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign axisFire  = AXIS_OUT_TVALID && AXIS_OUT_TREADY;
  assign creditOk  = (32'(credit_q) + 32'(BLOCK_CYCLES)) <= 32'(FIFO_DEPTH);
  assign lastBeat  = (outCount_q == (totalBeats_q - 40'd1));

  always_comb begin
    busy_d       = busy_q;
    nBlocks_d    = nBlocks_q;
    totalBeats_d = totalBeats_q;
    outCount_d   = outCount_q;
    reqCount_d   = reqCount_q;
    arAddr_d     = arAddr_q;
    arState_d    = arState_q;
    credit_d     = credit_q;
    blocksRead_d = blocksRead_q;
    readErr_d    = readErr_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;

    if (startAcc) begin
      nBlocks_d    = nClamp;
      totalBeats_d = 40'(nClamp) * 40'(BLOCK_CYCLES);
      outCount_d   = 40'd0;
      reqCount_d   = 32'd0;
      arAddr_d     = BASE_ADDR;
      blocksRead_d = 32'd0;
      readErr_d    = 1'b0;
      busy_d       = (nClamp != 32'd0);
    end

    if (rPush) begin
      wrPtr_d = wrPtr_q + PW'(1);
      if (M_AXI_RLAST) begin
        blocksRead_d = blocksRead_q + 32'd1;
      end
      if (M_AXI_RRESP != 2'b00) begin
        readErr_d = 1'b1;
      end
    end

    if (axisFire) begin
      rdPtr_d    = rdPtr_q + PW'(1);
      outCount_d = outCount_q + 40'd1;
      if (AXIS_OUT_TLAST) begin
        busy_d = 1'b0;
      end
    end

    // A block is only requested once the FIFO is guaranteed room for all of it.
    case (arState_q)
      ST_IDLE: begin
        if (busy_q && (reqCount_q < nBlocks_q) && creditOk) begin
          arState_d = ST_ADDR;
        end
      end
      default: begin
        if (M_AXI_ARREADY) begin
          arState_d  = ST_IDLE;
          reqCount_d = reqCount_q + 32'd1;
          arAddr_d   = arAddr_q + BLOCK_BYTES;
        end
      end
    endcase

    if (arFire && !axisFire) begin
      credit_d = credit_q + PW'(BLOCK_CYCLES);
    end else if (arFire && axisFire) begin
      credit_d = credit_q + PW'(BLOCK_CYCLES - 1);
    end else if (axisFire) begin
      credit_d = credit_q - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= 1'b0;
      nBlocks_q    <= 32'd0;
      totalBeats_q <= 40'd0;
      outCount_q   <= 40'd0;
      reqCount_q   <= 32'd0;
      arAddr_q     <= BASE_ADDR;
      arState_q    <= ST_IDLE;
      credit_q     <= '0;
      blocksRead_q <= 32'd0;
      readErr_q    <= 1'b0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
    end else begin
      busy_q       <= busy_d;
      nBlocks_q    <= nBlocks_d;
      totalBeats_q <= totalBeats_d;
      outCount_q   <= outCount_d;
      reqCount_q   <= reqCount_d;
      arAddr_q     <= arAddr_d;
      arState_q    <= arState_d;
      credit_q     <= credit_d;
      blocksRead_q <= blocksRead_d;
      readErr_q    <= readErr_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rPush) begin
      fifoMem_q[wrPtr_q[AW-1:0]] <= M_AXI_RDATA;
    end
  end

  assign busy            = busy_q;
  assign ram_blocks_read = blocksRead_q;
  assign read_error      = readErr_q;

  assign AXIS_OUT_TVALID = !fifoEmpty;
  assign AXIS_OUT_TDATA  = fifoMem_q[rdPtr_q[AW-1:0]];
  assign AXIS_OUT_TLAST  = !fifoEmpty && busy_q && lastBeat;

  assign M_AXI_ARVALID = (arState_q == ST_ADDR);
  assign M_AXI_ARADDR  = arAddr_q;
  assign M_AXI_ARLEN   = 8'(BLOCK_CYCLES - 1);
  assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARID    = 4'd0;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_RREADY  = !rst;

endmodule
